// File: rtl/systolic_array_ctrl.sv
// Sequencer for a ROWS x COLS weight-stationary systolic array: clear, row-wise weight load, skewed compute, drain.
// Optional SYSTOLIC_CTRL_PERF_CNT_EN adds busy-cycle and activation-bubble counters. Requires ROWS >= 2 and COLS >= 2.
module systolic_array_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             reuse_w,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             wet_valid,
  output logic             wet_ready,
  output logic [ROWS-1:0]  weight_load_en,
  output logic             PE_clear_weight,
  input  logic             act_valid,
  output logic             act_ready,
  output logic [ROWS-1:0]  PE_mac_enable,
  output logic [COLS-1:0]  out_valid,
  output logic             busy,
  output logic             done
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_bubbles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_W, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DRAIN_W = $clog2(ROWS + COLS);
  localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LEN = DRAIN_W'(ROWS + COLS - 2);

  state_t             r_state;
  logic               r_busy, r_done, r_clear, r_wet_ready, r_act_ready;
  logic [CNT_W-1:0]   r_num_vec;
  logic [CNT_W-1:0]   r_vec_cnt;
  logic [ROW_W-1:0]   r_row_idx;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [ROWS-2:0]    r_mac_sr;
  logic [COLS-1:0]    r_out_sr;

  logic               w_wet_hs;
  logic               w_acc;
  logic               w_last_vec;
  logic [ROWS-1:0]    w_mac_en;

  assign w_wet_hs   = wet_valid & r_wet_ready;
  assign w_acc      = act_valid & r_act_ready;
  assign w_last_vec = (r_vec_cnt == (r_num_vec - CNT_W'(1)));
  // Row r sees the accepted vector r cycles after row 0.
  assign w_mac_en   = {r_mac_sr, w_acc};

  assign wet_ready       = r_wet_ready;
  assign weight_load_en  = ROWS'(w_wet_hs) << r_row_idx;
  assign PE_clear_weight = r_clear;
  assign act_ready       = r_act_ready;
  assign PE_mac_enable   = w_mac_en;
  assign out_valid       = r_out_sr;
  assign busy            = r_busy;
  assign done            = r_done;

  // NOTE: state-decoded outputs are set on the transition into the state, so they come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_clear     <= 1'b0;
      r_wet_ready <= 1'b0;
      r_act_ready <= 1'b0;
      r_num_vec   <= '0;
      r_vec_cnt   <= '0;
      r_row_idx   <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_vec <= num_vec;
            r_vec_cnt <= '0;
            r_row_idx <= '0;
            r_busy    <= 1'b1;
            if (!reuse_w) begin
              r_state <= S_CLEAR;
              r_clear <= 1'b1;
            end else if (num_vec != '0) begin
              r_state     <= S_COMPUTE;
              r_act_ready <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          r_clear     <= 1'b0;
          r_wet_ready <= 1'b1;
          r_state     <= S_LOAD_W;
        end
        S_LOAD_W: begin
          if (w_wet_hs) begin
            r_row_idx <= r_row_idx + ROW_W'(1);
            if (r_row_idx == LAST_ROW) begin
              r_wet_ready <= 1'b0;
              if (r_num_vec != '0) begin
                r_state     <= S_COMPUTE;
                r_act_ready <= 1'b1;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        S_COMPUTE: begin
          if (w_acc) begin
            r_vec_cnt <= r_vec_cnt + CNT_W'(1);
            if (w_last_vec) begin
              r_act_ready <= 1'b0;
              r_drain_cnt <= DRAIN_LEN;
              r_state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Column c fires ROWS+c cycles after acceptance: one hop past the last row, then one per column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mac_sr <= '0;
      r_out_sr <= '0;
    end else begin
      r_mac_sr <= w_mac_en[ROWS-2:0];
      r_out_sr <= {r_out_sr[COLS-2:0], w_mac_en[ROWS-1]};
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles  <= '0;
      perf_bubbles <= '0;
    end else if (r_state == S_IDLE && start) begin
      perf_cycles  <= '0;
      perf_bubbles <= '0;
    end else begin
      if (r_busy && perf_cycles != '1)
        perf_cycles <= perf_cycles + 32'd1;
      if (r_state == S_COMPUTE && !act_valid && perf_bubbles != '1)
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
- Sequencer for a ROWS x COLS weight-stationary systolic array of multiply-accumulate PEs.
- Clears the stationary weights, loads them row by row over a valid/ready stream, then streams activation vectors.
- Generates the per-row skewed MAC enables, per-column output-valid strobes and a completion pulse.
- Sits between the host/DMA command interface and the PE grid.

Parameters:
ROWS, 4, number of PE rows (weight rows / activation lanes)
COLS, 4, number of PE columns (output lanes)
CNT_W, 16, width of the vector-count field

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  command strobe, sampled only in IDLE
reuse_w  input  1  sampled with start; 1 = keep current weights, skip CLEAR and LOAD_W
num_vec  input  CNT_W  number of activation vectors for this command, sampled with start
wet_valid  input  1  weight row beat valid
wet_ready  output  1  weight row beat accepted
weight_load_en  output  ROWS  one-hot row load strobe to PE weight registers
PE_clear_weight  output  1  clear all PE weight registers
act_valid  input  1  activation vector valid
act_ready  output  1  activation vector accepted
PE_mac_enable  output  ROWS  per-row skewed MAC/activation-inject enable
out_valid  output  COLS  per-column result-valid at bottom of array
busy  output  1  high in any state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters and skew pipeline cleared. Applies immediately, including mid-operation.
- FSM states: IDLE, CLEAR, LOAD_W, COMPUTE, DRAIN, DONE.
- IDLE:
  - start=1 latches num_vec and reuse_w.
  - Next state: reuse_w=0 -> CLEAR; reuse_w=1 and num_vec!=0 -> COMPUTE; reuse_w=1 and num_vec=0 -> DONE.
- CLEAR:
  - Exactly 1 cycle with PE_clear_weight=1.
  - Next state: LOAD_W.
- LOAD_W:
  - wet_ready=1; weight_load_en = (wet_valid & wet_ready) << row_idx (combinational).
  - row_idx runs 0..ROWS-1 and advances only on a handshake.
  - After the beat with row_idx=ROWS-1: next state COMPUTE if num_vec!=0, else DONE.
  - wet_valid gaps stall indefinitely.
- COMPUTE:
  - act_ready=1; acc = act_valid & act_ready; vec counter increments on acc.
  - Skew pipeline: PE_mac_enable[0]=acc; PE_mac_enable[r] = acc delayed r cycles (shift register).
  - Bubbles (act_valid=0) propagate as 0 slots.
  - After the acc with count = num_vec-1: next state DRAIN, act_ready drops the following cycle.
- Output timing:
  - A vector accepted at cycle t produces out_valid[c]=1 at cycle t+ROWS+c.
  - This comes from a second shift register fed by PE_mac_enable[ROWS-1].
- DRAIN:
  - Lasts ROWS+COLS-1 cycles (down-counter); skew pipelines keep shifting.
  - The last out_valid[COLS-1] falls in the final DRAIN cycle.
  - Next state: DONE.
- DONE:
  - done=1 for 1 cycle, then IDLE. busy=0 from the IDLE cycle on.
  - start is ignored in DONE; a new command needs start in IDLE.
- start while busy: ignored, no queueing.
- PE_mac_enable and out_valid are 0 outside COMPUTE/DRAIN except for in-flight shifted slots. In-flight slots are only possible during DRAIN.
- num_vec compare uses the latched value; num_vec = 2^CNT_W-1 is legal.

Optional Feature:
- Macro: SYSTOLIC_CTRL_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_cycles (32 bit): counts cycles with busy=1.
  - perf_bubbles (32 bit): counts COMPUTE cycles with act_valid=0.
- Both counters clear on the start handshake and saturate at all-ones. Reset value 0.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- ROWS=COLS=4, start with reuse_w=0, num_vec=3, wet_valid and act_valid held 1:
  - Expect 1 cycle PE_clear_weight.
  - Expect weight_load_en 0001,0010,0100,1000 on 4 consecutive cycles.
  - PE_mac_enable[r] high for 3 cycles starting r cycles after the first acc.
  - out_valid[c] first at acc0+4+c; done exactly once, 7 cycles after COMPUTE exit.
- Weight stall: wet_valid toggles 1,0,0,1,1,0,1 -> weight_load_en pulses only on valid cycles, in row order; COMPUTE entered after the 4th beat.
- Activation bubble: num_vec=2, act_valid 1,0,1 -> PE_mac_enable[0] = 1,0,1; PE_mac_enable[3] shows the same pattern 3 cycles later; out_valid[0] = 1,0,1 starting acc0+4.
- reuse_w=1, num_vec=1 -> no PE_clear_weight, no weight_load_en, COMPUTE entered the cycle after start. reuse_w=1, num_vec=0 -> done pulse 1 cycle after start.
- start asserted in DRAIN and DONE -> ignored. Reset asserted mid-COMPUTE -> all outputs 0 asynchronously, IDLE after release, next start runs normally.
- SYSTOLIC_CTRL_PERF_CNT_EN defined, bubble scenario -> perf_bubbles=1 and perf_cycles equals the counted busy cycles at done.
